// File: rtl/carfield_pkg.sv
// -----------------------------------------------------------------------------
// carfield_pkg
// Shared definitions for the Carfield island power sequencer:
//   - island_pwr_state_e : per-island power FSM state
//   - island index constants (SafetyIdx, PulpIdx, SpatzIdx, SecurityIdx)
//   - DefaultDomainEnable : generate mask built from the island enable flags
//   - island_pwr_out_t / island_pwr_decode : state -> island control outputs
//   - pwr_cnt_width : width of the shared reset/timeout down-counter
// -----------------------------------------------------------------------------
package carfield_pkg;

  localparam int unsigned NumIslands  = 4;

  localparam int unsigned SafetyIdx   = 0;
  localparam int unsigned PulpIdx     = 1;
  localparam int unsigned SpatzIdx    = 2;
  localparam int unsigned SecurityIdx = 3;

  localparam bit SafetyEnable   = 1'b1;
  localparam bit PulpEnable     = 1'b1;
  localparam bit SpatzEnable    = 1'b1;
  localparam bit SecurityEnable = 1'b1;

  localparam logic [NumIslands-1:0] DefaultDomainEnable =
    {SecurityEnable, SpatzEnable, PulpEnable, SafetyEnable};

  typedef enum logic [2:0] {
    PWR_OFF,
    PWR_CLK_ON,
    PWR_RST_REL,
    PWR_DEISO,
    PWR_ON,
    PWR_ISO,
    PWR_RST_ON
  } island_pwr_state_e;

  typedef struct packed {
    logic isolate;
    logic clk_en;
    logic rst_n;
    logic active;
    logic busy;
  } island_pwr_out_t;

  // Island control levels for a given state. OFF is the safe default:
  // isolated, clock gated, reset held.
  function automatic island_pwr_out_t island_pwr_decode(input island_pwr_state_e s);
    island_pwr_out_t o;
    o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, active: 1'b0, busy: 1'b0};
    case (s)
      PWR_CLK_ON:  begin o.clk_en = 1'b1; o.busy = 1'b1; end
      PWR_RST_REL: begin o.clk_en = 1'b1; o.rst_n = 1'b1; o.busy = 1'b1; end
      PWR_DEISO:   begin o.isolate = 1'b0; o.clk_en = 1'b1; o.rst_n = 1'b1; o.busy = 1'b1; end
      PWR_ON:      begin o.isolate = 1'b0; o.clk_en = 1'b1; o.rst_n = 1'b1; o.active = 1'b1; end
      PWR_ISO:     begin o.clk_en = 1'b1; o.rst_n = 1'b1; o.busy = 1'b1; end
      PWR_RST_ON:  begin o.clk_en = 1'b1; o.busy = 1'b1; end
      default:     ;
    endcase
    return o;
  endfunction

  // One counter serves both the reset-hold count and the isolation timeout.
  function automatic int unsigned pwr_cnt_width(input int unsigned rst_cycles,
                                                input int unsigned iso_timeout);
    int unsigned m;
    m = (rst_cycles > iso_timeout) ? rst_cycles : iso_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/carfield_island_pwr_seq_fsm.sv
// -----------------------------------------------------------------------------
// carfield_island_pwr_fsm
// Power sequencer for a single island: one state machine plus its shared
// down-counter. Orders clock enable, reset release and de-isolation on the
// way up, and isolation, reset assertion and clock gating on the way down.
// Ports:
//   clk_i, rst_ni       host clock, asynchronous active-low reset
//   req_on_i, req_off_i single-cycle power-on / power-off requests
//   iso_ack_i           1 = island cut isolated and drained
//   isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o  registered controls
// -----------------------------------------------------------------------------
module carfield_island_pwr_fsm
  import carfield_pkg::*;
#(
  parameter bit          Enable     = 1'b1,
  parameter int unsigned RstCycles  = 8,
  parameter int unsigned IsoTimeout = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_on_i,
  input  logic req_off_i,
  input  logic iso_ack_i,
  output logic isolate_o,
  output logic clk_en_o,
  output logic rst_no,
  output logic active_o,
  output logic busy_o,
  output logic err_o
);

  localparam int unsigned CntW = pwr_cnt_width(RstCycles, IsoTimeout);
  // Counter is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] IsoLoad = CntW'(IsoTimeout - 1);

  island_pwr_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  island_pwr_out_t   out_q;

  // Simultaneous on/off is ambiguous and is ignored; a disabled island never
  // sees a request, so it stays OFF with err clear.
  logic req_on, req_off, cnt_zero;
  assign req_on   = Enable & req_on_i  & ~req_off_i;
  assign req_off  = Enable & req_off_i & ~req_on_i;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      PWR_OFF: begin
        if (req_on) begin
          state_d = PWR_CLK_ON;
          cnt_d   = RstLoad;
          err_d   = 1'b0;
        end
      end
      PWR_CLK_ON: begin
        if (cnt_zero) state_d = PWR_RST_REL;
        else          cnt_d   = cnt_q - CntW'(1);
      end
      PWR_RST_REL: begin
        state_d = PWR_DEISO;
        cnt_d   = IsoLoad;
      end
      PWR_DEISO: begin
        if (!iso_ack_i) begin
          state_d = PWR_ON;
        end else if (cnt_zero) begin
          state_d = PWR_ON;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
        end
      end
      PWR_ON: begin
        if (req_off) begin
          state_d = PWR_ISO;
          cnt_d   = IsoLoad;
        end
      end
      PWR_ISO: begin
        if (iso_ack_i) begin
          state_d = PWR_RST_ON;
          cnt_d   = RstLoad;
        end else if (cnt_zero) begin
          state_d = PWR_RST_ON;
          cnt_d   = RstLoad;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
        end
      end
      PWR_RST_ON: begin
        if (cnt_zero) state_d = PWR_OFF;
        else          cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = PWR_OFF;
    endcase
  end

  // Outputs are registered from the decoded next state, so they change
  // together with the state flops and never combinationally with inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PWR_OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= island_pwr_decode(PWR_OFF);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= island_pwr_decode(state_d);
    end
  end

  assign isolate_o = out_q.isolate;
  assign clk_en_o  = out_q.clk_en;
  assign rst_no    = out_q.rst_n;
  assign active_o  = out_q.active;
  assign busy_o    = out_q.busy;
  assign err_o     = err_q;

endmodule

// File: rtl/carfield_island_pwr_seq.sv
// -----------------------------------------------------------------------------
// carfield_island_pwr_seq
// Power-up/power-down sequencer for the optional Carfield islands
// (0 safety, 1 PULP, 2 Spatz, 3 security). One independent FSM per island.
// Ports (all vectors NumDomains wide, bit i = island i):
//   clk_i, rst_ni  host clock, asynchronous active-low reset
//   req_on_i       single-cycle power-on request
//   req_off_i      single-cycle power-off request
//   iso_ack_i      1 = island cut isolated and drained
//   isolate_o      isolation request to the cut
//   clk_en_o       island clock-gate enable
//   rst_no         island reset, active-low
//   active_o       island ON and de-isolated
//   busy_o         power sequence in progress
//   err_o          sticky isolation-handshake timeout
// -----------------------------------------------------------------------------
module carfield_island_pwr_seq
  import carfield_pkg::*;
#(
  parameter int unsigned             NumDomains   = 4,
  parameter logic [NumDomains-1:0]   DomainEnable = NumDomains'(DefaultDomainEnable),
  parameter int unsigned             RstCycles    = 8,
  parameter int unsigned             IsoTimeout   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumDomains-1:0] req_on_i,
  input  logic [NumDomains-1:0] req_off_i,
  input  logic [NumDomains-1:0] iso_ack_i,
  output logic [NumDomains-1:0] isolate_o,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] rst_no,
  output logic [NumDomains-1:0] active_o,
  output logic [NumDomains-1:0] busy_o,
  output logic [NumDomains-1:0] err_o
);

  for (genvar i = 0; i < NumDomains; i++) begin : gen_island
    carfield_island_pwr_fsm #(
      .Enable     (DomainEnable[i]),
      .RstCycles  (RstCycles),
      .IsoTimeout (IsoTimeout)
    ) i_fsm (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_on_i  (req_on_i[i]),
      .req_off_i (req_off_i[i]),
      .iso_ack_i (iso_ack_i[i]),
      .isolate_o (isolate_o[i]),
      .clk_en_o  (clk_en_o[i]),
      .rst_no    (rst_no[i]),
      .active_o  (active_o[i]),
      .busy_o    (busy_o[i]),
      .err_o     (err_o[i])
    );
  end

endmodule

// File: tb/tb_carfield_island_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_carfield_island_pwr_seq
// Bench for carfield_island_pwr_seq with RstCycles=8, IsoTimeout=16 and
// island 2 disabled. Stimulus tasks push the output edges they expect
// (cycle, signal, island, value) into a queue; a monitor pops each observed
// edge against the queue and flags unexpected or missing edges.
// -----------------------------------------------------------------------------
module tb_carfield_island_pwr_seq;

  localparam int ND    = 4;
  localparam int RST   = 8;
  localparam int ISOTO = 16;

  localparam int S_ISO  = 0;
  localparam int S_CLK  = 1;
  localparam int S_RST  = 2;
  localparam int S_ACT  = 3;
  localparam int S_BUSY = 4;
  localparam int S_ERR  = 5;

  typedef struct {
    int   cyc;
    int   sig;
    int   dom;
    logic val;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] req_on, req_off, iso_ack;
  logic [ND-1:0] isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o;

  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  bit  exp_err [ND];
  ev_t exp_q [$];

  carfield_island_pwr_seq #(
    .NumDomains   (ND),
    .DomainEnable (4'b1011),
    .RstCycles    (RST),
    .IsoTimeout   (ISOTO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_on_i  (req_on),
    .req_off_i (req_off),
    .iso_ack_i (iso_ack),
    .isolate_o (isolate_o),
    .clk_en_o  (clk_en_o),
    .rst_no    (rst_no),
    .active_o  (active_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string sig_name(input int s);
    case (s)
      S_ISO:   return "isolate_o";
      S_CLK:   return "clk_en_o";
      S_RST:   return "rst_no";
      S_ACT:   return "active_o";
      S_BUSY:  return "busy_o";
      default: return "err_o";
    endcase
  endfunction

  // Scoreboard monitor: every output edge must match a queued expectation,
  // and every expectation must be consumed by its cycle.
  logic [ND-1:0] prv [6];
  always @(negedge clk) begin
    logic [ND-1:0] cur [6];
    bit found;
    cur[S_ISO]  = isolate_o;
    cur[S_CLK]  = clk_en_o;
    cur[S_RST]  = rst_no;
    cur[S_ACT]  = active_o;
    cur[S_BUSY] = busy_o;
    cur[S_ERR]  = err_o;
    if (mon_en) begin
      for (int s = 0; s < 6; s++) begin
        for (int d = 0; d < ND; d++) begin
          if (cur[s][d] !== prv[s][d]) begin
            found = 1'b0;
            for (int j = 0; j < exp_q.size(); j++) begin
              if (!found && exp_q[j].cyc == cyc && exp_q[j].sig == s &&
                  exp_q[j].dom == d && exp_q[j].val === cur[s][d]) begin
                exp_q.delete(j);
                found = 1'b1;
              end
            end
            n_checks++;
            if (!found) begin
              n_fail++;
              $display("FAIL sb_unexpected %s[%0d] cycle %0d: got %b, required %b (no edge expected)",
                       sig_name(s), d, cyc, cur[s][d], prv[s][d]);
            end
          end
        end
      end
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].cyc <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_missing %s[%0d] cycle %0d: got %b, required %b",
                   sig_name(exp_q[j].sig), exp_q[j].dom, exp_q[j].cyc,
                   cur[exp_q[j].sig][exp_q[j].dom], exp_q[j].val);
          exp_q.delete(j);
        end
      end
    end
    prv = cur;
  end

  task automatic push(input int c, input int s, input int d, input logic v);
    ev_t e;
    e = '{cyc: c, sig: s, dom: d, val: v};
    exp_q.push_back(e);
  endtask

  // Advance to #1 after the rising edge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Power-on of island d. iso_ack drops k cycles after DEISO entry.
  // With inject set, requests that must be dropped are sprinkled in.
  task automatic do_power_on(input int d, input int k, input bit inject);
    int c0;
    c0 = cyc;
    req_on[d] = 1'b1;
    if (exp_err[d]) push(c0 + 1, S_ERR, d, 1'b0);
    exp_err[d] = 1'b0;
    push(c0 + 1,           S_CLK,  d, 1'b1);
    push(c0 + 1,           S_BUSY, d, 1'b1);
    push(c0 + 1 + RST,     S_RST,  d, 1'b1);
    push(c0 + 2 + RST,     S_ISO,  d, 1'b0);
    push(c0 + 3 + RST + k, S_ACT,  d, 1'b1);
    push(c0 + 3 + RST + k, S_BUSY, d, 1'b0);
    goto(c0 + 1);
    req_on[d] = 1'b0;
    if (inject) begin
      goto(c0 + 3);  req_on[d]  = 1'b1;
      goto(c0 + 4);  req_on[d]  = 1'b0;
      goto(c0 + 11); req_off[d] = 1'b1;
      goto(c0 + 12); req_off[d] = 1'b0;
    end
    goto(c0 + 2 + RST + k);
    iso_ack[d] = 1'b0;
    if (inject) begin
      goto(c0 + 16); req_on[d] = 1'b1; req_off[d] = 1'b1;
      goto(c0 + 17); req_on[d] = 1'b0; req_off[d] = 1'b0;
      goto(c0 + 24);
    end
    goto(c0 + 5 + RST + k);
  endtask

  // Power-off of island d. iso_ack rises k cycles after ISO entry, or never
  // (timeout) in which case it is raised once the island is OFF.
  task automatic do_power_off(input int d, input int k, input bit timeout);
    int c0;
    int rc;
    c0 = cyc;
    req_off[d] = 1'b1;
    push(c0 + 1, S_ACT,  d, 1'b0);
    push(c0 + 1, S_ISO,  d, 1'b1);
    push(c0 + 1, S_BUSY, d, 1'b1);
    if (timeout) begin
      rc = c0 + 1 + ISOTO;
      push(rc, S_ERR, d, 1'b1);
      exp_err[d] = 1'b1;
    end else begin
      rc = c0 + 2 + k;
    end
    push(rc,       S_RST,  d, 1'b0);
    push(rc + RST, S_CLK,  d, 1'b0);
    push(rc + RST, S_BUSY, d, 1'b0);
    goto(c0 + 1);
    req_off[d] = 1'b0;
    if (!timeout) begin
      goto(c0 + 1 + k);
      iso_ack[d] = 1'b1;
    end
    goto(rc + RST + 2);
    iso_ack[d] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req_on  = '0;
    req_off = '0;
    iso_ack = '1;
    for (int d = 0; d < ND; d++) exp_err[d] = 1'b0;
    @(posedge clk);
    #1;
    goto(cyc + 3);
    rst_n = 1'b1;
    n_checks++; if (isolate_o !== 4'b1111) begin n_fail++; $display("FAIL reset_isolate: got %b required 1111", isolate_o); end
    n_checks++; if (clk_en_o  !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_en: got %b required 0000", clk_en_o); end
    n_checks++; if (rst_no    !== 4'b0000) begin n_fail++; $display("FAIL reset_rst_n: got %b required 0000", rst_no); end
    n_checks++; if (active_o  !== 4'b0000) begin n_fail++; $display("FAIL reset_active: got %b required 0000", active_o); end
    n_checks++; if (busy_o    !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b required 0000", busy_o); end
    n_checks++; if (err_o     !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b required 0000", err_o); end
    mon_en = 1'b1;
    goto(cyc + 20);
    n_checks++;
    if ({isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o} !== 24'hF00000) begin
      n_fail++;
      $display("FAIL reset_hold: got %h required f00000",
               {isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o});
    end
  endtask

  task automatic test_power_on();
    do_power_on(1, 3, 1'b0);
    n_checks++; if (active_o !== 4'b0010) begin n_fail++; $display("FAIL on_active: got %b required 0010", active_o); end
    n_checks++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL on_err: got %b required 0000", err_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL on_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_power_off_timeout();
    int c0;
    c0 = cyc;
    fork
      do_power_off(1, 0, 1'b1);
      begin
        goto(c0 + 16);
        n_checks++; if (err_o[1] !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b required 0", err_o[1]); end
        goto(c0 + 17);
        n_checks++; if (err_o[1] !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b required 1", err_o[1]); end
      end
    join
    n_checks++; if ({clk_en_o[1], rst_no[1], err_o[1]} !== 3'b001) begin n_fail++; $display("FAIL to_off_state: got %b required 001", {clk_en_o[1], rst_no[1], err_o[1]}); end
    do_power_on(1, 3, 1'b0);
    n_checks++; if (err_o[1] !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b required 0", err_o[1]); end
    n_checks++; if (active_o[1] !== 1'b1) begin n_fail++; $display("FAIL to_reon_active: got %b required 1", active_o[1]); end
  endtask

  task automatic test_dropped_requests();
    do_power_off(1, 2, 1'b0);
    n_checks++; if (busy_o[1] !== 1'b0 || clk_en_o[1] !== 1'b0) begin n_fail++; $display("FAIL drop_off: got busy %b clk_en %b required 0 0", busy_o[1], clk_en_o[1]); end
    do_power_on(1, 3, 1'b1);
    n_checks++; if (active_o[1] !== 1'b1 || busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL drop_end_on: got active %b busy %b required 1 0", active_o[1], busy_o[1]); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_disabled_domain();
    int c0;
    c0 = cyc;
    fork
      begin req_on[2] = 1'b1; goto(c0 + 1); req_on[2] = 1'b0; end
      do_power_on(0, 2, 1'b0);
      do_power_off(1, 4, 1'b0);
      begin goto(c0 + 3); do_power_on(3, 5, 1'b0); end
    join
    n_checks++; if (busy_o[2] !== 1'b0) begin n_fail++; $display("FAIL dis_busy2: got %b required 0", busy_o[2]); end
    n_checks++; if ({isolate_o[2], clk_en_o[2], rst_no[2], err_o[2]} !== 4'b1000) begin n_fail++; $display("FAIL dis_off2: got %b required 1000", {isolate_o[2], clk_en_o[2], rst_no[2], err_o[2]}); end
    n_checks++; if (active_o !== 4'b1001) begin n_fail++; $display("FAIL dis_active: got %b required 1001", active_o); end
  endtask

  task automatic test_mid_sequence_reset();
    int c0;
    mon_en = 1'b0;
    c0 = cyc;
    req_on[1]  = 1'b1;
    req_off[0] = 1'b1;
    goto(c0 + 1);
    req_on[1]  = 1'b0;
    req_off[0] = 1'b0;
    goto(c0 + 3);
    n_checks++; if ({clk_en_o[1], rst_no[1], busy_o[1]} !== 3'b101) begin n_fail++; $display("FAIL mid_clk_on: got %b required 101", {clk_en_o[1], rst_no[1], busy_o[1]}); end
    n_checks++; if ({isolate_o[0], active_o[0], busy_o[0]} !== 3'b101) begin n_fail++; $display("FAIL mid_iso: got %b required 101", {isolate_o[0], active_o[0], busy_o[0]}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (isolate_o !== 4'b1111) begin n_fail++; $display("FAIL mid_isolate: got %b required 1111", isolate_o); end
    n_checks++; if (clk_en_o  !== 4'b0000) begin n_fail++; $display("FAIL mid_clk_en: got %b required 0000", clk_en_o); end
    n_checks++; if (rst_no    !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_n: got %b required 0000", rst_no); end
    n_checks++; if (active_o  !== 4'b0000) begin n_fail++; $display("FAIL mid_active: got %b required 0000", active_o); end
    n_checks++; if (busy_o    !== 4'b0000) begin n_fail++; $display("FAIL mid_busy: got %b required 0000", busy_o); end
    n_checks++; if (err_o     !== 4'b0000) begin n_fail++; $display("FAIL mid_err: got %b required 0000", err_o); end
    goto(cyc + 3);
    rst_n   = 1'b1;
    iso_ack = '1;
    for (int d = 0; d < ND; d++) exp_err[d] = 1'b0;
    mon_en = 1'b1;
    goto(cyc + 5);
    n_checks++;
    if ({isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o} !== 24'hF00000) begin
      n_fail++;
      $display("FAIL mid_after_release: got %h required f00000",
               {isolate_o, clk_en_o, rst_no, active_o, busy_o, err_o});
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_power_off_timeout();
    test_dropped_requests();
    test_disabled_domain();
    test_mid_sequence_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
